sine_stim_gen: RTL and testbench
================================

Name: sine_stim_gen

Overview:
- Digital DDS tone source. Sits directly upstream of the bandpass filter stage and supplies its input samples, playing the role the 1 V / 1 kHz AC source plays in the analog bench.
- Generates signed sine samples from a phase accumulator and a quarter-wave LUT, scales them by a programmable amplitude, and streams them over a valid/ready interface.
- Supports continuous runs or bursts of N whole periods, with glitch-free frequency and amplitude updates.

Parameters:
- PHASE_W, 32, phase accumulator width.
- LUT_AW, 8, quarter-wave LUT address width (2^LUT_AW entries).
- DATA_W, 16, signed output sample width.
- AMP_W, 16, unsigned amplitude width (Q0.AMP_W).
- BURST_W, 16, period counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cfg_freq_word  in  PHASE_W  phase increment per sample
- cfg_amp  in  AMP_W  amplitude scale
- cfg_phase0  in  PHASE_W  start phase
- cfg_burst  in  BURST_W  periods per run; 0 = continuous
- start  in  1  single-cycle run request
- stop  in  1  single-cycle graceful stop request
- busy  out  1  run in progress (RUN or DRAIN)
- done  out  1  single-cycle pulse at end of run
- m_valid  out  1  sample valid
- m_ready  in  1  downstream accepts
- m_data  out  DATA_W  signed sample

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is synchronous and active-low.
- Reset values: busy=0, done=0, m_valid=0, m_data=0, phase=0, period count=0, FSM=IDLE, stop_pending=0, pipeline valids=0.
- LUT contents: LUT[i] = round(sin((i+0.5)·π/(2·2^LUT_AW))·(2^(DATA_W-1)−1)).
  - The half-index offset makes quadrant mirroring exact.
- Address mapping:
  - quadrant q = phase[PHASE_W-1:PHASE_W-2].
  - idx = phase[PHASE_W-3 -: LUT_AW]; idx = ~idx when q[0]=1.
  - Result is negative when q[1]=1.
- Scaling: mag_s = (LUT[idx]·amp) >> AMP_W (unsigned floor), then negated if q[1]=1. No saturation is needed.
- Pipeline: 4 stages (phase/issue, address, LUT register, multiply/sign → m_data register).
  - First m_valid appears 4 cycles after the start cycle when m_ready=1.
  - Steady-state throughput is 1 sample/cycle.
- Backpressure: global stall when m_valid && !m_ready.
  - The whole pipeline and the accumulator freeze.
  - m_data and m_valid are held stable.
  - The sample sequence is identical to the unstalled case.
- FSM IDLE:
  - On start: latch freq/amp/burst, set phase=cfg_phase0, count=0 → RUN.
  - stop in IDLE is ignored.
- FSM RUN, per advance:
  - Issue the sample for the current phase.
  - Update phase += fw (mod 2^PHASE_W).
  - On carry-out (wrap): count++; re-latch cfg_freq_word and cfg_amp. New values apply only from the sample after the wrap.
  - If (burst≠0 && count==burst) or stop_pending: issue nothing further → DRAIN.
- FSM DRAIN: once all pipeline stages are empty and the last sample is accepted → done=1 for one cycle, busy=0 → IDLE.
- start while busy: ignored.
- stop while RUN: sets stop_pending; the run terminates at the next wrap.
  - If the latched fw==0, the run terminates immediately (next cycle → DRAIN).
- Simultaneous wrap and stop: treated as stop_pending already set (terminates at this wrap).
- Reset mid-run: everything returns to reset values. done is not pulsed, and in-flight samples are discarded.

Decomposition:
- Package sine_stim_pkg holds:
  - default widths;
  - the FSM state enum (IDLE, RUN, DRAIN);
  - the LUT generation function (used at elaboration).
- Sub-module sine_qlut: registered quarter-wave ROM with clock enable, LUT_AW in, DATA_W-1 magnitude out.

Test Plan:
- Burst run: fw=0x00400000, amp=0xFFFF, phase0=0, burst=1, m_ready=1.
  - Exactly 1024 samples, then done.
  - Values: s[0]=100, s[255]=s[256]=32766, s[512]=−100, s[768]=−32766.
  - First m_valid 4 cycles after start.
- Amplitude: same run with amp=0x8000 → peak 16383 / −16383; all other samples exactly half, floored before sign.
- Backpressure: m_ready random 50% duty → same 1024-value sequence; m_data unchanged on every stalled cycle; done only after the last accept.
- Frequency update: continuous run; change fw to 0x00800000 at sample 100.
  - Samples 101–1023 keep the old step.
  - The new step starts at sample 1024 (phase 0); period 2 has 512 samples.
- Stop: continuous run, stop at sample 300 → last sample is 1023, done follows the drain; start during busy has no effect.
- Edge and reset cases:
  - fw=0 with stop → terminates within 1 cycle (plus drain).
  - rst_n low at sample 500 → next cycle m_valid=0, busy=0, no done; a new start resumes from cfg_phase0.

Source files
------------

// File: rtl/sine_stim_pkg.sv
// Shared definitions for the sine stimulus generator.
// Holds the default widths, the run-control FSM state type and the
// elaboration-time quarter-wave table generator used by sine_qlut.
package sine_stim_pkg;

    localparam int unsigned DEF_PHASE_W = 32;
    localparam int unsigned DEF_LUT_AW  = 8;
    localparam int unsigned DEF_DATA_W  = 16;
    localparam int unsigned DEF_AMP_W   = 16;
    localparam int unsigned DEF_BURST_W = 16;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    // Entry i of a 2^aw quarter-wave table, full scale 2^(dw-1)-1.
    // Sampling at (i + 0.5) makes the mirrored quadrants exact copies.
    function automatic int lut_entry(int i, int aw, int dw);
        real pi;
        real x;
        pi = 3.14159265358979323846;
        x  = $sin(($itor(i) + 0.5) * pi / (2.0 * $itor(1 << aw)))
             * $itor((1 << (dw - 1)) - 1);
        return $rtoi(x + 0.5);
    endfunction

endpackage

// File: rtl/sine_stim_gen_if.sv
// Sample stream between the tone source and its consumer.
//   m_valid : sample valid (master -> slave)
//   m_ready : consumer accepts (slave -> master)
//   m_data  : signed sample (master -> slave)
interface sine_stim_gen_if
    import sine_stim_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/sine_qlut.sv
// Registered quarter-wave sine ROM with clock enable.
//   clk  : clock
//   en   : load the output register
//   addr : quarter-wave index
//   mag  : unsigned magnitude, DATA_W-1 bits, valid the cycle after en
module sine_qlut
    import sine_stim_pkg::*;
#(
    parameter int unsigned LUT_AW = DEF_LUT_AW,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              en,
    input  logic [LUT_AW-1:0] addr,
    output logic [DATA_W-2:0] mag
);
    localparam int unsigned DEPTH = 1 << LUT_AW;
    localparam int unsigned MAG_W = DATA_W - 1;

    logic [MAG_W-1:0] rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom[i] = MAG_W'(lut_entry(i, LUT_AW, DATA_W));
    end

    always_ff @(posedge clk) begin
        if (en) begin
            mag <= rom[addr];
        end
    end
endmodule

// File: rtl/sine_stim_gen.sv
// DDS tone source: phase accumulator + quarter-wave LUT + amplitude scaling,
// streamed over valid/ready. Runs continuously or for cfg_burst whole periods.
//   clk, rst_n    : clock, synchronous active-low reset
//   cfg_freq_word : phase step per sample (re-latched at each period wrap)
//   cfg_amp       : Q0.AMP_W amplitude (re-latched at each period wrap)
//   cfg_phase0    : start phase
//   cfg_burst     : periods per run, 0 = continuous
//   start, stop   : single-cycle run / graceful stop requests
//   busy, done    : run in progress, end-of-run pulse
//   stream        : sample stream master
module sine_stim_gen
    import sine_stim_pkg::*;
#(
    parameter int unsigned PHASE_W = DEF_PHASE_W,
    parameter int unsigned LUT_AW  = DEF_LUT_AW,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned AMP_W   = DEF_AMP_W,
    parameter int unsigned BURST_W = DEF_BURST_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PHASE_W-1:0] cfg_freq_word,
    input  logic [AMP_W-1:0]   cfg_amp,
    input  logic [PHASE_W-1:0] cfg_phase0,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               start,
    input  logic               stop,
    output logic               busy,
    output logic               done,
    sine_stim_gen_if.master    stream
);
    localparam int unsigned MAG_W  = DATA_W - 1;
    localparam int unsigned PROD_W = MAG_W + AMP_W;

    state_e             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_sum, fw_q;
    logic               carry;
    logic [AMP_W-1:0]   amp_q;
    logic [BURST_W-1:0] burst_q, count_q, count_inc;
    logic               stop_pending_q;
    logic               stall, advance, issue, load, drain_done, pipe_empty, last_period;

    logic               v1_q, v2_q, v3_q;
    logic [LUT_AW+1:0]  p1_q;
    logic [LUT_AW-1:0]  idx_d, idx2_q;
    logic               neg2_q, neg3_q;
    logic [AMP_W-1:0]   a1_q, a2_q, a3_q;
    logic [MAG_W-1:0]   mag3, scaled;
    logic [PROD_W-1:0]  prod;
    logic [DATA_W-1:0]  mag_ext, sample;
    logic               m_valid_q, done_q;
    logic [DATA_W-1:0]  m_data_q;

    // Everything, accumulator included, freezes while the output is refused.
    assign stall   = m_valid_q && !stream.m_ready;
    assign advance = !stall;

    assign {carry, phase_sum} = {1'b0, phase_q} + {1'b0, fw_q};
    assign count_inc   = count_q + BURST_W'(1);
    assign last_period = (burst_q != '0) && (count_inc == burst_q);
    assign pipe_empty  = !v1_q && !v2_q && !v3_q;

    always_comb begin
        state_d    = state_q;
        issue      = 1'b0;
        load       = 1'b0;
        drain_done = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (advance) begin
                    issue = 1'b1;
                    // A stop arriving on the wrap cycle counts as already pending.
                    if (carry && (last_period || stop_pending_q || stop)) begin
                        state_d = StDrain;
                    end else if (fw_q == '0 && stop_pending_q) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (pipe_empty && (!m_valid_q || stream.m_ready)) begin
                    drain_done = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            done_q         <= 1'b0;
            phase_q        <= '0;
            fw_q           <= '0;
            amp_q          <= '0;
            burst_q        <= '0;
            count_q        <= '0;
            stop_pending_q <= 1'b0;
            v1_q           <= 1'b0;
            v2_q           <= 1'b0;
            v3_q           <= 1'b0;
            m_valid_q      <= 1'b0;
            m_data_q       <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= drain_done;
            if (load) begin
                fw_q    <= cfg_freq_word;
                amp_q   <= cfg_amp;
                burst_q <= cfg_burst;
                phase_q <= cfg_phase0;
                count_q <= '0;
            end else if (issue) begin
                phase_q <= phase_sum;
                if (carry) begin
                    count_q <= count_inc;
                    fw_q    <= cfg_freq_word;
                    amp_q   <= cfg_amp;
                end
            end
            if (load) begin
                stop_pending_q <= 1'b0;
            end else if (state_q == StRun && stop) begin
                stop_pending_q <= 1'b1;
            end
            if (advance) begin
                v1_q      <= issue;
                v2_q      <= v1_q;
                v3_q      <= v2_q;
                m_valid_q <= v3_q;
                if (v3_q) begin
                    m_data_q <= sample;
                end
            end
        end
    end

    // Datapath registers; qualified by the valid bits above.
    always_ff @(posedge clk) begin
        if (advance) begin
            p1_q   <= phase_q[PHASE_W-1 -: LUT_AW+2];
            a1_q   <= amp_q;
            idx2_q <= idx_d;
            neg2_q <= p1_q[LUT_AW+1];
            a2_q   <= a1_q;
            neg3_q <= neg2_q;
            a3_q   <= a2_q;
        end
    end

    // Odd quadrants walk the table backwards.
    assign idx_d = p1_q[LUT_AW] ? ~p1_q[LUT_AW-1:0] : p1_q[LUT_AW-1:0];

    sine_qlut #(
        .LUT_AW(LUT_AW),
        .DATA_W(DATA_W)
    ) u_qlut (
        .clk (clk),
        .en  (advance),
        .addr(idx2_q),
        .mag (mag3)
    );

    assign prod    = {{AMP_W{1'b0}}, mag3} * {{MAG_W{1'b0}}, a3_q};
    assign scaled  = MAG_W'(prod >> AMP_W);
    assign mag_ext = {1'b0, scaled};
    assign sample  = neg3_q ? -mag_ext : mag_ext;

    assign busy           = (state_q != StIdle);
    assign done           = done_q;
    assign stream.m_valid = m_valid_q;
    assign stream.m_data  = m_data_q;
endmodule

// File: tb/tb_sine_stim_gen.sv
// Self-checking bench for sine_stim_gen: expected samples come from a
// floating-point sine model of the tone, checked on every accepted sample.
module tb_sine_stim_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cfg_freq_word;
    logic [15:0] cfg_amp;
    logic [31:0] cfg_phase0;
    logic [15:0] cfg_burst;
    logic        start, stop;
    logic        busy, done;

    sine_stim_gen_if #(.DATA_W(16)) bus ();

    sine_stim_gen #(
        .PHASE_W(32),
        .LUT_AW (8),
        .DATA_W (16),
        .AMP_W  (16),
        .BURST_W(16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_freq_word(cfg_freq_word),
        .cfg_amp      (cfg_amp),
        .cfg_phase0   (cfg_phase0),
        .cfg_burst    (cfg_burst),
        .start        (start),
        .stop         (stop),
        .busy         (busy),
        .done         (done),
        .stream       (bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          exp_q[$];
    int          got [8192];
    int          acc_cnt = 0;
    int          acc_base = 0;
    int          done_cnt = 0;
    int          done_base = 0;
    logic        bp_en = 1'b0;
    logic        fixed_mode = 1'b0;
    int          fixed_val = 0;
    logic        hold_pend = 1'b0;
    logic [15:0] hold_data = '0;
    logic        prev_done = 1'b0;

    task automatic chk(string name, longint act, longint want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, want);
        end
    endtask

    // Reference tone: exact sine table, floor scaling, sign from the top phase bit.
    function automatic int exp_sample(logic [31:0] ph, logic [15:0] amp);
        int     idx;
        int     lut;
        longint prod;
        int     mag;
        real    x;
        idx = int'(ph[29:22]);
        if (ph[30]) idx = 255 - idx;
        x    = $sin(($itor(idx) + 0.5) * 3.14159265358979 / 512.0) * 32767.0;
        lut  = $rtoi(x + 0.5);
        prod = longint'(lut) * longint'(amp);
        mag  = int'(prod >>> 16);
        return ph[31] ? -mag : mag;
    endfunction

    // Queue the sample stream of a run lasting 'periods' wraps; fw2 applies after wrap 1.
    task automatic model_run(logic [31:0] ph0, logic [31:0] fw1, logic [31:0] fw2,
                             logic [15:0] amp, int periods);
        longint      ph = longint'(ph0);
        logic [31:0] fw = fw1;
        int          wraps = 0;
        while (wraps < periods) begin
            exp_q.push_back(exp_sample(ph[31:0], amp));
            ph = ph + longint'(fw);
            if (ph >= 64'h1_0000_0000) begin
                ph = ph - 64'h1_0000_0000;
                wraps++;
                fw = fw2;
            end
        end
    endtask

    function automatic int g(int k);
        return got[(acc_base + k) % 8192];
    endfunction

    // Per-cycle output check, sampled on the falling edge.
    task automatic cycle_check();
        int sdata;
        sdata = int'($signed(bus.m_data));
        if (!rst_n) begin
            hold_pend = 1'b0;
            prev_done = 1'b0;
            return;
        end
        if (hold_pend) begin
            chk("stall_valid", longint'(bus.m_valid), 1);
            chk("stall_data", longint'(bus.m_data), longint'(hold_data));
        end
        hold_pend = bus.m_valid && !bus.m_ready;
        hold_data = bus.m_data;
        if (bus.m_valid && bus.m_ready) begin
            if (fixed_mode) chk("fixed_sample", sdata, fixed_val);
            else if (exp_q.size() == 0) chk("extra_sample", 1, 0);
            else chk($sformatf("sample[%0d]", acc_cnt - acc_base), sdata, exp_q.pop_front());
            got[acc_cnt % 8192] = sdata;
            acc_cnt++;
        end
        if (done) begin
            done_cnt++;
            chk("done_after_last", exp_q.size(), 0);
            chk("done_single", longint'(prev_done), 0);
            chk("done_no_valid", longint'(bus.m_valid), 0);
            chk("done_not_busy", longint'(busy), 0);
        end
        prev_done = done;
    endtask

    task automatic tick();
        @(negedge clk);
        cycle_check();
        @(posedge clk);
        #1;
        bus.m_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic start_run(logic [31:0] ph0, logic [31:0] fw, logic [15:0] amp,
                             logic [15:0] burst);
        cfg_phase0    = ph0;
        cfg_freq_word = fw;
        cfg_amp       = amp;
        cfg_burst     = burst;
        acc_base      = acc_cnt;
        done_base     = done_cnt;
        start         = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic wait_acc(int n, int budget, string name);
        int k = 0;
        while (acc_cnt - acc_base < n && k < budget) begin
            tick();
            k++;
        end
        chk(name, longint'(acc_cnt - acc_base >= n), 1);
    endtask

    task automatic wait_done(int budget, string name);
        int k = 0;
        while (done_cnt == done_base && k < budget) begin
            tick();
            k++;
        end
        chk(name, done_cnt - done_base, 1);
    endtask

    initial begin
        int          n_exp;
        int          tail;
        int          d0;
        logic [31:0] ph;
        logic [31:0] fw;
        logic [15:0] amp;
        logic [15:0] bst;

        rst_n         = 1'b0;
        cfg_freq_word = '0;
        cfg_amp       = '0;
        cfg_phase0    = '0;
        cfg_burst     = '0;
        start         = 1'b0;
        stop          = 1'b0;
        bus.m_ready   = 1'b1;
        repeat (3) tick();
        chk("rst_valid", longint'(bus.m_valid), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_data", longint'(bus.m_data), 0);
        rst_n = 1'b1;
        tick();

        // Pin the model to hand-computed values.
        chk("model_s0", exp_sample(32'd0, 16'hFFFF), 100);
        chk("model_s255", exp_sample(32'd255 << 22, 16'hFFFF), 32766);
        chk("model_s256", exp_sample(32'd256 << 22, 16'hFFFF), 32766);
        chk("model_s512", exp_sample(32'd512 << 22, 16'hFFFF), -100);
        chk("model_s768", exp_sample(32'd768 << 22, 16'hFFFF), -32766);
        chk("model_half", exp_sample(32'd255 << 22, 16'h8000), 16383);

        // One-period burst, full scale, no backpressure.
        model_run(32'd0, 32'h0040_0000, 32'h0040_0000, 16'hFFFF, 1);
        start_run(32'd0, 32'h0040_0000, 16'hFFFF, 16'd1);
        repeat (3) tick();
        chk("latency_early", longint'(bus.m_valid), 0);
        chk("busy_run", longint'(busy), 1);
        tick();
        chk("latency_4", longint'(bus.m_valid), 1);
        wait_done(3000, "burst_done");
        chk("burst_count", acc_cnt - acc_base, 1024);
        chk("burst_s0", g(0), 100);
        chk("burst_s255", g(255), 32766);
        chk("burst_s256", g(256), 32766);
        chk("burst_s512", g(512), -100);
        chk("burst_s768", g(768), -32766);

        // Half amplitude.
        model_run(32'd0, 32'h0040_0000, 32'h0040_0000, 16'h8000, 1);
        start_run(32'd0, 32'h0040_0000, 16'h8000, 16'd1);
        wait_done(3000, "amp_done");
        chk("amp_count", acc_cnt - acc_base, 1024);
        chk("amp_peak", g(255), 16383);
        chk("amp_trough", g(768), -16383);
        chk("amp_s0", g(0), 50);

        // Same burst under random backpressure.
        bp_en = 1'b1;
        model_run(32'd0, 32'h0040_0000, 32'h0040_0000, 16'hFFFF, 1);
        start_run(32'd0, 32'h0040_0000, 16'hFFFF, 16'd1);
        wait_done(8000, "bp_done");
        chk("bp_count", acc_cnt - acc_base, 1024);

        // Frequency change mid-period takes effect after the wrap.
        model_run(32'd0, 32'h0040_0000, 32'h0080_0000, 16'hFFFF, 2);
        start_run(32'd0, 32'h0040_0000, 16'hFFFF, 16'd0);
        wait_acc(100, 1000, "freq_reach100");
        cfg_freq_word = 32'h0080_0000;
        wait_acc(1100, 5000, "freq_reach1100");
        pulse_stop();
        wait_done(3000, "freq_done");
        chk("freq_count", acc_cnt - acc_base, 1536);
        chk("freq_p2_s0", g(1024), 100);
        chk("freq_p2_s128", g(1152), 32766);

        // Stop in period 1, ignored start while busy.
        model_run(32'd0, 32'h0040_0000, 32'h0040_0000, 16'hFFFF, 1);
        start_run(32'd0, 32'h0040_0000, 16'hFFFF, 16'd0);
        wait_acc(300, 1500, "stop_reach300");
        pulse_stop();
        wait_acc(500, 1500, "stop_reach500");
        cfg_phase0    = 32'h1234_5678;
        cfg_freq_word = 32'h0100_0000;
        start         = 1'b1;
        tick();
        start = 1'b0;
        wait_done(3000, "stop_done");
        chk("stop_count", acc_cnt - acc_base, 1024);

        // Stop while idle does nothing.
        d0 = done_cnt;
        pulse_stop();
        repeat (6) tick();
        chk("idle_stop_busy", longint'(busy), 0);
        chk("idle_stop_done", done_cnt, d0);
        chk("idle_stop_valid", longint'(bus.m_valid), 0);

        // Zero step: constant output, stop ends the run almost at once.
        bp_en      = 1'b0;
        fixed_mode = 1'b1;
        fixed_val  = exp_sample(32'h5A00_0000, 16'hC000);
        start_run(32'h5A00_0000, 32'd0, 16'hC000, 16'd0);
        wait_acc(10, 100, "fw0_reach10");
        tail = acc_cnt;
        pulse_stop();
        wait_done(10, "fw0_done");
        chk("fw0_tail", longint'(acc_cnt - tail <= 8), 1);
        fixed_mode = 1'b0;

        // Reset mid-run, then restart from a new phase.
        bp_en = 1'b1;
        model_run(32'd0, 32'h0040_0000, 32'h0040_0000, 16'hFFFF, 2);
        start_run(32'd0, 32'h0040_0000, 16'hFFFF, 16'd0);
        wait_acc(500, 3000, "rst_reach500");
        d0    = done_cnt;
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        chk("midrst_valid", longint'(bus.m_valid), 0);
        chk("midrst_busy", longint'(busy), 0);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("midrst_no_done", done_cnt, d0);
        ph = $urandom;
        model_run(ph, 32'h0040_0000, 32'h0040_0000, 16'hFFFF, 1);
        n_exp = exp_q.size();
        start_run(ph, 32'h0040_0000, 16'hFFFF, 16'd1);
        wait_done(8000, "restart_done");
        chk("restart_count", acc_cnt - acc_base, n_exp);

        // Random configurations under backpressure.
        for (int r = 0; r < 4; r++) begin
            ph  = $urandom;
            fw  = $urandom_range(32'h1000_0000, 32'h0100_0000);
            amp = 16'($urandom_range(0, 65535));
            bst = 16'($urandom_range(1, 3));
            model_run(ph, fw, fw, amp, int'(bst));
            n_exp = exp_q.size();
            start_run(ph, fw, amp, bst);
            wait_done(6000, $sformatf("rand%0d_done", r));
            chk($sformatf("rand%0d_count", r), acc_cnt - acc_base, n_exp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
